// File: rtl/regbank_rr_arb_pkg.sv
// Shared types for the round-robin register bank: controller state, response record,
// requester limit and the pointer wrap helper.
package regbank_arb_pkg;

    localparam int MAX_NUM_REQ    = 8;
    localparam int MAX_DATA_WIDTH = 64;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [MAX_NUM_REQ-1:0]    valid;
        logic [MAX_DATA_WIDTH-1:0] rdata;
    } rsp_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regbank_rr_arb_if.sv
// Request/response bundle between CSR-issuing agents and the register bank controller.
// req_lock_i only exists when REGBANK_ARB_LOCK_EN is defined.
interface regbank_rr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);

    logic [NUM_REQ-1:0]                 req_valid_i;
    logic [NUM_REQ-1:0]                 req_ready_o;
    logic [NUM_REQ-1:0]                 req_we_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
`ifdef REGBANK_ARB_LOCK_EN
    logic [NUM_REQ-1:0]                 req_lock_i;
`endif
    logic [NUM_REQ-1:0]                 rsp_valid_o;
    logic [DATA_WIDTH-1:0]              rsp_rdata_o;

    modport master (
        output req_valid_i,
        output req_we_i,
        output req_addr_i,
        output req_wdata_i,
`ifdef REGBANK_ARB_LOCK_EN
        output req_lock_i,
`endif
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_rdata_o
    );

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  req_addr_i,
        input  req_wdata_i,
`ifdef REGBANK_ARB_LOCK_EN
        input  req_lock_i,
`endif
        output req_ready_o,
        output rsp_valid_o,
        output rsp_rdata_o
    );

endinterface

// File: rtl/dfferc.sv
// Enable-loaded flop with asynchronous active-low reset to a parameterised value.
module dfferc #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/regbank_rr_arb_rr_pick.sv
// Combinational one-hot priority picker: first set request at or after ptr_i, wrapping
// modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr_i) + off) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/regbank_rr_arb.sv
// Shared configuration register bank behind a round-robin access controller, one grant
// per cycle, registered response one cycle later. Grant locking under REGBANK_ARB_LOCK_EN.
//   state  | meaning
//   ARB    | round-robin among all valid requesters starting at ptr
//   LOCKED | only owner may be granted until it releases the lock
module regbank_rr_arb
    import regbank_arb_pkg::*;
#(
    parameter int                    NUM_REQ    = 4,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input logic             clk_i,
    input logic             rst_n_i,
    regbank_rr_arb_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [NUM_REQ-1:0]              lock_mask;
    logic [NUM_REQ-1:0]              elig;
    logic [NUM_REQ-1:0]              gnt;
    logic [PTR_W-1:0]                gidx;
    logic                            xfer;
    logic [PTR_W-1:0]                ptr_q;
    logic [PTR_W-1:0]                ptr_d;
    logic                            sel_we;
    logic [ADDR_WIDTH-1:0]           sel_addr;
    logic [DATA_WIDTH-1:0]           sel_wdata;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] bank_q;
    logic [NUM_REQ-1:0]              rsp_valid_q;
    logic [DATA_WIDTH-1:0]           rsp_rdata_q;
    logic [DATA_WIDTH-1:0]           rsp_rdata_d;

    // Reset gates eligibility so ready stays low while rst_n_i is asserted.
    assign elig = bus.req_valid_i & lock_mask & {NUM_REQ{rst_n_i}};

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_pick (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (xfer)
    );

    assign bus.req_ready_o = gnt;

    assign sel_we    = bus.req_we_i[gidx];
    assign sel_addr  = bus.req_addr_i[gidx];
    assign sel_wdata = bus.req_wdata_i[gidx];

    assign ptr_d = PTR_W'(rr_next(int'(gidx), NUM_REQ));

    dfferc #(
        .W       (PTR_W),
        .RST_VAL ('0)
    ) u_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (xfer),
        .d_i     (ptr_d),
        .q_o     (ptr_q)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_bank
        logic wr_en;
        assign wr_en = xfer && sel_we && (sel_addr == ADDR_WIDTH'(i));

        dfferc #(
            .W       (DATA_WIDTH),
            .RST_VAL (RESET_VAL)
        ) u_entry (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .en_i    (wr_en),
            .d_i     (sel_wdata),
            .q_o     (bank_q[i])
        );
    end

    // Only one op per cycle, so a read never races a write to the same entry.
    assign rsp_rdata_d = (xfer && !sel_we) ? bank_q[sel_addr] : '0;

    dfferc #(
        .W       (NUM_REQ),
        .RST_VAL ('0)
    ) u_rsp_valid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (1'b1),
        .d_i     (gnt),
        .q_o     (rsp_valid_q)
    );

    dfferc #(
        .W       (DATA_WIDTH),
        .RST_VAL ('0)
    ) u_rsp_rdata (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (1'b1),
        .d_i     (rsp_rdata_d),
        .q_o     (rsp_rdata_q)
    );

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

`ifdef REGBANK_ARB_LOCK_EN
    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [0:0]       state_raw;
    logic [PTR_W-1:0] owner_q;
    logic [PTR_W-1:0] owner_d;

    dfferc #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_state (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (1'b1),
        .d_i     (state_d),
        .q_o     (state_raw)
    );

    assign state_q = arb_state_e'(state_raw);

    dfferc #(
        .W       (PTR_W),
        .RST_VAL ('0)
    ) u_owner (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (1'b1),
        .d_i     (owner_d),
        .q_o     (owner_q)
    );

    assign lock_mask = (state_q == LOCKED) ? (NUM_REQ'(1) << owner_q) : '1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB: begin
                if (xfer && bus.req_lock_i[gidx]) begin
                    state_d = LOCKED;
                    owner_d = gidx;
                end
            end
            LOCKED: begin
                // In LOCKED any transfer is the owner's; release on unlocked transfer or idle.
                if (!bus.req_lock_i[owner_q] && (xfer || !bus.req_valid_i[owner_q])) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end
`else
    assign lock_mask = '1;
`endif

endmodule

// File: tb/tb_regbank_rr_arb.sv
// Directed bench for regbank_rr_arb: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them against the DUT response port.
module tb_regbank_rr_arb;
    import regbank_arb_pkg::*;

    localparam int                NR   = 4;
    localparam int                AW   = 4;
    localparam int                DW   = 32;
    localparam logic [DW-1:0]     RVAL = 32'hA5A5_0F0F;

    typedef struct {
        rsp_t  rsp;
        int    due;
        string nm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    regbank_rr_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regbank_rr_arb #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_VAL  (RVAL)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input int r, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid_i[r] = v;
        bus.req_we_i[r]    = we;
        bus.req_addr_i[r]  = a;
        bus.req_wdata_i[r] = d;
    endtask

    task automatic idle_all();
        bus.req_valid_i = '0;
        bus.req_we_i    = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
`ifdef REGBANK_ARB_LOCK_EN
        bus.req_lock_i  = '0;
`endif
    endtask

    task automatic check_ready(input logic [NR-1:0] exp_rdy, input string nm);
        total++;
        if (bus.req_ready_o !== exp_rdy) begin
            bad++;
            $display("FAIL %s ready got=%b exp=%b", nm, bus.req_ready_o, exp_rdy);
        end
    endtask

    // Inputs are already set (posedge+1); check ready mid-cycle, queue the response.
    task automatic step(input logic [NR-1:0] exp_rdy, input logic [DW-1:0] exp_rdata,
                        input string nm);
        exp_t e;
        @(negedge clk);
        check_ready(exp_rdy, nm);
        if (exp_rdy != '0) begin
            e.rsp             = '0;
            e.rsp.valid[NR-1:0] = exp_rdy;
            e.rsp.rdata[DW-1:0] = exp_rdata;
            e.due             = cyc + 1;
            e.nm              = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_out_zero(input string nm);
        total++;
        if (bus.req_ready_o !== '0 || bus.rsp_valid_o !== '0 || bus.rsp_rdata_o !== '0) begin
            bad++;
            $display("FAIL %s outputs got ready=%b rsp_valid=%b rdata=%h exp all zero",
                     nm, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid_i = '1;
        #1;
        check_out_zero("reset_hold");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out_zero("reset_ready_masked");
        idle_all();
        rst_n = 1'b1;
    endtask

    // Monitor: compare every response against the queue head, including its due cycle.
    initial begin
        exp_t e;
        rsp_t act;
        forever begin
            @(negedge clk);
            if (sb.size() != 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL %s rsp missing due=%0d now=%0d", e.nm, e.due, cyc);
            end
            if (bus.rsp_valid_o != '0) begin
                total++;
                act             = '0;
                act.valid[NR-1:0] = bus.rsp_valid_o;
                act.rdata[DW-1:0] = bus.rsp_rdata_o;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected got valid=%b rdata=%h exp none",
                             bus.rsp_valid_o, bus.rsp_rdata_o);
                end else begin
                    e = sb.pop_front();
                    if (act !== e.rsp || e.due != cyc) begin
                        bad++;
                        $display("FAIL %s rsp got valid=%b rdata=%h cyc=%0d exp valid=%b rdata=%h cyc=%0d",
                                 e.nm, bus.rsp_valid_o, bus.rsp_rdata_o, cyc,
                                 e.rsp.valid[NR-1:0], e.rsp.rdata[DW-1:0], e.due);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        total = 0;
        bad   = 0;
        idle_all();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single read after reset returns the reset value.
        drive(2, 1'b1, 1'b0, 4'd5, '0);
        step(4'b0100, RVAL, "single_read");
        idle_all();
        step(4'b0000, '0, "single_idle");

        // ptr=3: req0 wins after wrap; write then read-after-write.
        drive(0, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
        step(4'b0001, 32'h0, "write_a3");
        idle_all();
        drive(1, 1'b1, 1'b0, 4'd3, '0);
        step(4'b0010, 32'hDEAD_BEEF, "read_a3");
        idle_all();
        step(4'b0000, '0, "wr_rd_idle");

        // Contention from reset: order 0,1,2,3,0 with consecutive read-after-write.
        @(posedge clk);
        #1;
        do_reset();
        drive(0, 1'b1, 1'b1, 4'd8, 32'h0000_0011);
        drive(1, 1'b1, 1'b0, 4'd8, '0);
        drive(2, 1'b1, 1'b1, 4'd9, 32'h0000_0022);
        drive(3, 1'b1, 1'b0, 4'd9, '0);
        step(4'b0001, 32'h0,          "cont_g0");
        step(4'b0010, 32'h0000_0011,  "cont_g1");
        step(4'b0100, 32'h0,          "cont_g2");
        step(4'b1000, 32'h0000_0022,  "cont_g3");
        step(4'b0001, 32'h0,          "cont_g0b");
        idle_all();
        step(4'b0000, '0, "cont_idle");

        // Withdrawal: req3 valid only during req2's grant; ptr then sits at 3.
        drive(2, 1'b1, 1'b0, 4'd9, '0);
        drive(3, 1'b1, 1'b0, 4'd8, '0);
        step(4'b0100, 32'h0000_0022, "wd_g2");
        idle_all();
        step(4'b0000, '0, "wd_gone");
        for (int r = 0; r < NR; r++) drive(r, 1'b1, 1'b0, 4'd8, '0);
        step(4'b1000, 32'h0000_0011, "wd_ptr3");
        idle_all();
        step(4'b0000, '0, "wd_idle");

`ifdef REGBANK_ARB_LOCK_EN
        drive(0, 1'b1, 1'b0, 4'd9, '0);
        step(4'b0001, 32'h0000_0022, "lk_pre");
        for (int r = 0; r < NR; r++) drive(r, 1'b1, 1'b0, 4'd8, '0);
        bus.req_lock_i = 4'b0010;
        step(4'b0010, 32'h0000_0011, "lk_take");
        step(4'b0010, 32'h0000_0011, "lk_hold1");
        step(4'b0010, 32'h0000_0011, "lk_hold2");
        bus.req_lock_i = 4'b0000;
        step(4'b0010, 32'h0000_0011, "lk_release");
        step(4'b0100, 32'h0000_0011, "lk_after");
        idle_all();
        step(4'b0000, '0, "lk_idle");
`endif

        // Async reset mid-stream: write addr7, then reset while a read is granted.
        drive(0, 1'b1, 1'b1, 4'd7, 32'h1234_5678);
        step(4'b0001, 32'h0, "mr_write7");
        idle_all();
        drive(1, 1'b1, 1'b0, 4'd7, '0);
        @(negedge clk);
        check_ready(4'b0010, "mr_read_granted");
        #1;
        rst_n = 1'b0;
        #1;
        check_out_zero("mr_async_clear");
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_all();
        rst_n = 1'b1;
        step(4'b0000, '0, "mr_no_pending");
        for (int r = 0; r < NR; r++) drive(r, 1'b1, 1'b0, 4'd7, '0);
        step(4'b0001, RVAL, "mr_bank7_reset");
        idle_all();
        step(4'b0000, '0, "mr_idle");
        @(posedge clk);
        @(negedge clk);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank_rr_arb.md
# regbank_rr_arb

Shared configuration register bank with a round-robin access controller. Up to NUM_REQ masters issue single-beat read/write requests over valid/ready; the controller grants one per cycle, commits writes into an internal bank of 2**ADDR_WIDTH enable-loaded registers, and returns a registered response one cycle after grant. It sits between CSR-issuing agents (core, debug, DMA) and peripheral configuration state.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_WIDTH, 4: bank address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32: register width
- RESET_VAL, '0: reset value of every bank entry (DATA_WIDTH bits)
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  request valid per requester
- req_ready_o  out  NUM_REQ  grant; transfer when valid & ready
- req_we_i  in  NUM_REQ  1 = write, 0 = read
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  register address
- req_wdata_i  in  NUM_REQ x DATA_WIDTH  write data
- req_lock_i  in  NUM_REQ  hold grant after this transfer (only with REGBANK_ARB_LOCK_EN)
- rsp_valid_o  out  NUM_REQ  one-hot response pulse to the requester served last cycle
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for write responses

## Operation
- Each cycle at most one req_ready_o bit high, only for a requester with valid high; ready depends combinationally on valid.
- Requester holds valid, we, addr, wdata stable until transfer; dropping valid before transfer is legal (request withdrawn).
- Round-robin: priority starts at ptr, wraps modulo NUM_REQ; after a transfer by g, ptr <= (g+1) mod NUM_REQ. No transfer: ptr unchanged.
- Write transfer: bank[addr] <= wdata at the clock edge ending the grant cycle.
- Read transfer: rsp_rdata_o <= bank[addr] at same edge (pre-write value impossible: one op per cycle).
- Read-after-write to same address in consecutive grants returns new data.
- States (with macro): ARB, LOCKED. ARB -> LOCKED on transfer by g with req_lock_i[g]=1; owner <= g. In LOCKED only owner may be granted. LOCKED -> ARB on owner transfer with lock 0, or a cycle with owner valid 0 and lock 0. ptr still advances on owner transfers.
- Reset mid-operation: all state cleared asynchronously; granted-but-unresponded transfer produces no response.

## Timing
- Grant latency: 0 cycles when uncontended (ready same cycle as valid).
- Response latency: exactly 1 cycle after transfer; rsp_valid_o high for one cycle; back-to-back responses every cycle.
- Worst-case wait in ARB with all requesting: NUM_REQ-1 cycles.
- Reset values: req_ready_o 0 (during reset), rsp_valid_o 0, rsp_rdata_o 0, bank = RESET_VAL, ptr 0, state ARB, owner 0.

## Configuration
- REGBANK_ARB_LOCK_EN defined: req_lock_i present, ARB/LOCKED FSM active.
- Undefined: req_lock_i port absent, controller permanently in ARB, pure round-robin.

## Structure
- Package regbank_arb_pkg: state enum (ARB, LOCKED), response struct (valid vector, rdata), max NUM_REQ constant.
- Sub-module rr_pick: combinational one-hot priority picker given request vector and ptr.
- Bank entries, ptr, owner, state, response registers built from the team's enable/reset flop primitives (dfferc for bank with RESET_VAL).

## Test plan
- Single read after reset: req 2 reads addr 5 -> ready[2] same cycle, next cycle rsp_valid_o=4'b0100, rdata = RESET_VAL.
- Write then read: req 0 writes 0xDEADBEEF to addr 3, next cycle req 1 reads addr 3 -> rdata 0xDEADBEEF, write response rdata 0.
- Contention: all 4 valid continuously from reset -> grant order 0,1,2,3,0, one per cycle, responses 1 cycle behind.
- Lock (macro on): req 1 transfers with lock=1 while 0,2,3 valid -> next three grants all to 1 until lock=0 transfer, then grant 2.
- Withdrawal: req 3 valid one cycle while req 2 granted, then drops -> no transfer or response for 3, ptr = 3.
- Async reset asserted mid-stream after write to addr 7 -> outputs 0 immediately, bank[7] = RESET_VAL, no pending response after release.
